jtframe_dual_ram_clr: RTL and testbench

//  Single-clock true dual-port RAM with per-byte write enables and a built-in clear sequencer.

---
 rtl/jtframe_ram_pkg.sv | 24 ++
 rtl/jtframe_ram_clr_seq.sv | 78 +++++++
 rtl/jtframe_dual_ram_clr.sv | 190 +++++++++++++++++++
 tb/tb_jtframe_dual_ram_clr.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_ram_pkg.sv
// Shared definitions for the dual-port RAM with a clear sequencer.
// This package provides the clear FSM state encoding and a byte-lane mask helper.
package jtframe_ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // This is the widest lane count that lane_mask supports. Callers cast the result down to their own width.
  localparam int MAX_BW = 32;
  localparam int MAX_DW = 8 * MAX_BW;

  // Expand one enable bit per byte lane into a full-width bit mask.
  function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_BW-1:0] we);
    logic [MAX_DW-1:0] m;
    m = {MAX_DW{1'b0}};
    for (int i = 0; i < MAX_BW; i++) begin
      m[8*i +: 8] = {8{we[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/jtframe_ram_clr_seq.sv
// This is the clear sequencer. It walks an address counter over the whole RAM after reset or on request.
// While it runs, it drives busy, the clear address and a clear-write strobe.
module jtframe_ram_clr_seq
  import jtframe_ram_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  // The counter has one extra bit so that the terminal address is a plain compare and never wraps silently.
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};

  clr_state_e  state_d, state_q;
  logic [AW:0] cnt_d, cnt_q;
  logic        busy_d, busy_q;

  // Next-state logic. A clear request always restarts the sweep at address 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = CNT_ZERO;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (clr) begin
          cnt_d   = CNT_ZERO;
          busy_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + CNT_ONE;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = CNT_ZERO;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State register. Reset starts a fresh sweep from address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= CNT_ZERO;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign clr_addr = cnt_q[AW-1:0];
  assign clr_we   = (state_q == ST_CLEAR);

endmodule

// File: rtl/jtframe_dual_ram_clr.sv
// This is a single-clock true dual-port RAM with per-byte write enables and a built-in clear sweep.
// Optional macro JTFRAME_DUAL_RAM_FWD_EN: when defined, a write on one port at the address the other port
// is reading is forwarded per lane to that other port's q. Port 1 wins on collisions.
module jtframe_dual_ram_clr
  import jtframe_ram_pkg::*;
#(
  parameter int            DW     = 16,
  parameter int            AW     = 10,
  parameter int            BW     = DW / 8,
  parameter logic [DW-1:0] CLRVAL = {DW{1'b0}},
  parameter int            OUTREG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  input  logic [BW-1:0] we0,
  output logic [DW-1:0] q0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  input  logic [BW-1:0] we1,
  output logic [DW-1:0] q1
);

  localparam int DEPTH = 2 ** AW;

  logic [AW-1:0] clr_addr;
  logic          clr_we;
  logic          busy_s;

  jtframe_ram_clr_seq #(.AW(AW)) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy_s),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  assign busy = busy_s;

  logic [AW-1:0] wr0_addr;
  logic [DW-1:0] wr0_data;
  logic [BW-1:0] wr0_we;
  logic [BW-1:0] wr1_we;

  // Write arbitration. The clear sweep takes over port 0's write path, and user writes are dropped while busy.
  always_comb begin
    wr0_addr = addr0;
    wr0_data = data0;
    wr0_we   = {BW{1'b0}};
    wr1_we   = {BW{1'b0}};
    if (!rst_n) begin
      wr0_we   = {BW{1'b0}};
    end else if (busy_s) begin
      wr0_addr = clr_addr;
      wr0_data = CLRVAL;
      wr0_we   = {BW{clr_we}};
    end else begin
      wr0_we   = we0;
      wr1_we   = we1;
    end
  end

  logic [DW-1:0] rd0_raw, rd1_raw;

  for (genvar l = 0; l < BW; l++) begin : g_lane
    (* ramstyle = "no_rw_check" *) logic [7:0] mem [0:DEPTH-1];
    logic [7:0] rd0_lq, rd1_lq;

    // This process handles one byte lane. Reads are read-first, and the port 1 write is last so it wins a collision.
    always_ff @(posedge clk) begin
      if (wr0_we[l]) begin
        mem[wr0_addr] <= wr0_data[8*l +: 8];
      end
      if (wr1_we[l]) begin
        mem[addr1] <= data1[8*l +: 8];
      end
      rd0_lq <= mem[addr0];
      rd1_lq <= mem[addr1];
    end

    assign rd0_raw[8*l +: 8] = rd0_lq;
    assign rd1_raw[8*l +: 8] = rd1_lq;
  end

  logic vld_d, vld_q;

  // The read-valid flag keeps q at zero for the cycle after reset without putting a reset on the RAM read registers.
  always_comb begin
    vld_d = 1'b1;
  end

  // This register holds the read-valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  logic [DW-1:0] rd0_mux, rd1_mux;

`ifdef JTFRAME_DUAL_RAM_FWD_EN
  logic [BW-1:0] fwd0_d, fwd0_q, fwd1_d, fwd1_q;
  logic [DW-1:0] fdat0_d, fdat0_q, fdat1_d, fdat1_q;
  logic [DW-1:0] msk0, msk1;

  // Forwarding selection. Port 0 sees port 1's written lanes. Port 1 sees port 0's lanes except those port 1 also writes.
  always_comb begin
    fwd0_d  = (addr1 == addr0)    ? wr1_we             : {BW{1'b0}};
    fwd1_d  = (wr0_addr == addr1) ? (wr0_we & ~wr1_we) : {BW{1'b0}};
    fdat0_d = data1;
    fdat1_d = wr0_data;
  end

  // These registers align the forwarded data with the RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd0_q  <= {BW{1'b0}};
      fwd1_q  <= {BW{1'b0}};
      fdat0_q <= {DW{1'b0}};
      fdat1_q <= {DW{1'b0}};
    end else begin
      fwd0_q  <= fwd0_d;
      fwd1_q  <= fwd1_d;
      fdat0_q <= fdat0_d;
      fdat1_q <= fdat1_d;
    end
  end

  // Merge the forwarded lanes over the RAM read data.
  always_comb begin
    msk0    = DW'(lane_mask(MAX_BW'(fwd0_q)));
    msk1    = DW'(lane_mask(MAX_BW'(fwd1_q)));
    rd0_mux = (rd0_raw & ~msk0) | (fdat0_q & msk0);
    rd1_mux = (rd1_raw & ~msk1) | (fdat1_q & msk1);
  end
`else
  // Without forwarding, a cross-port read returns the RAM contents from before the write.
  always_comb begin
    rd0_mux = rd0_raw;
    rd1_mux = rd1_raw;
  end
`endif

  logic [DW-1:0] rd0_out, rd1_out;

  // Gate the read data to zero until the first read after reset.
  always_comb begin
    if (vld_q) begin
      rd0_out = rd0_mux;
      rd1_out = rd1_mux;
    end else begin
      rd0_out = {DW{1'b0}};
      rd1_out = {DW{1'b0}};
    end
  end

  if (OUTREG != 0) begin : g_oreg
    logic [DW-1:0] q0_d, q0_q, q1_d, q1_q;

    // The optional output register stage makes the read latency two cycles.
    always_comb begin
      q0_d = rd0_out;
      q1_d = rd1_out;
    end

    // This process holds the output pipeline registers.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q0_q <= {DW{1'b0}};
        q1_q <= {DW{1'b0}};
      end else begin
        q0_q <= q0_d;
        q1_q <= q1_d;
      end
    end

    assign q0 = q0_q;
    assign q1 = q1_q;
  end else begin : g_noreg
    assign q0 = rd0_out;
    assign q1 = rd1_out;
  end

endmodule

// File: tb/tb_jtframe_dual_ram_clr.sv
// This is the self-checking bench for jtframe_dual_ram_clr (AW=4, DW=16).
// It runs directed scenarios and a randomized phase, comparing the outputs cycle by cycle against a word-array model.
module tb_jtframe_dual_ram_clr;

  localparam int AW     = 4;
  localparam int DW     = 16;
  localparam int BW     = DW / 8;
  localparam int DEPTH  = 2 ** AW;
  localparam int OUTREG = 0;
  localparam int LAT    = 1 + OUTREG;
  localparam logic [DW-1:0] CLRV = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          busy;
  logic [AW-1:0] addr0 = 4'd0, addr1 = 4'd0;
  logic [DW-1:0] data0 = 16'h0000, data1 = 16'h0000;
  logic [BW-1:0] we0 = 2'b00, we1 = 2'b00;
  logic [DW-1:0] q0, q1;

  jtframe_dual_ram_clr #(.DW(DW), .AW(AW), .OUTREG(OUTREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .busy  (busy),
    .addr0 (addr0),
    .data0 (data0),
    .we0   (we0),
    .q0    (q0),
    .addr1 (addr1),
    .data1 (data1),
    .we1   (we1),
    .q1    (q1)
  );

  always #5 clk = ~clk;

  // These are the reference model state, the expected-read pipeline and the check counters.
  logic [DW-1:0] mem_m [DEPTH];
  bit            busy_m = 1'b1;
  logic [AW-1:0] ptr_m  = 4'd0;
  logic [DW-1:0] eq0 [$];
  logic [DW-1:0] eq1 [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Update the model from the current inputs, advance one clock, then compare outputs #1 after the edge.
  task automatic tick();
    logic [DW-1:0] e0, e1, w0d;
    logic [BW-1:0] w0we, w1we;
    logic [AW-1:0] w0a;
    if (!rst_n) begin
      busy_m = 1'b1;
      ptr_m  = 4'd0;
      eq0.delete();
      eq1.delete();
      for (int i = 0; i < LAT; i++) begin
        eq0.push_back(16'h0000);
        eq1.push_back(16'h0000);
      end
    end else begin
      e0 = mem_m[addr0];
      e1 = mem_m[addr1];
      if (busy_m) begin
        w0we = 2'b11; w0a = ptr_m; w0d = CLRV; w1we = 2'b00;
      end else begin
        w0we = we0; w0a = addr0; w0d = data0; w1we = we1;
      end
`ifdef JTFRAME_DUAL_RAM_FWD_EN
      for (int l = 0; l < BW; l++) begin
        if (w1we[l] && addr1 == addr0) e0[8*l +: 8] = data1[8*l +: 8];
        if (w0we[l] && !w1we[l] && w0a == addr1) e1[8*l +: 8] = w0d[8*l +: 8];
      end
`endif
      for (int l = 0; l < BW; l++) if (w0we[l]) mem_m[w0a][8*l +: 8] = w0d[8*l +: 8];
      for (int l = 0; l < BW; l++) if (w1we[l]) mem_m[addr1][8*l +: 8] = data1[8*l +: 8];
      if (busy_m) begin
        if (clr) ptr_m = 4'd0;
        else if (ptr_m == 4'd15) busy_m = 1'b0;
        else ptr_m = ptr_m + 4'd1;
      end else if (clr) begin
        busy_m = 1'b1;
        ptr_m  = 4'd0;
      end
      eq0.push_back(e0);
      eq1.push_back(e1);
    end
    @(posedge clk);
    #1;
    if (eq0.size() == LAT) begin
      chk("q0_model", q0, eq0.pop_front());
      chk("q1_model", q1, eq1.pop_front());
    end
    chk("busy_model", busy, busy_m);
  endtask

  // Count the cycles busy stays high from now on, with random writes that must be ignored. The count is bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      addr0 = AW'($urandom);
      addr1 = ptr_m + 4'd1;
      data0 = DW'($urandom);
      data1 = DW'($urandom);
      we0   = BW'($urandom);
      we1   = BW'($urandom);
      tick();
    end
    we0 = 2'b00;
    we1 = 2'b00;
  endtask

  task automatic fill_all(input logic [DW-1:0] v);
    for (int a = 0; a < DEPTH; a++) begin
      addr0 = AW'(a); data0 = v; we0 = 2'b11; tick();
    end
    we0 = 2'b00;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      addr0 = AW'(a); addr1 = AW'(DEPTH - 1 - a); tick();
    end
    repeat (LAT) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [DW-1:0] exp5;
    for (int a = 0; a < DEPTH; a++) mem_m[a] = 16'h0000;

    // The initial reset and its sweep.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_q0", q0, 16'h0000);
    chk("rst_q1", q1, 16'h0000);
    chk("rst_busy", busy, 1'b1);
    rst_n = 1'b1;
    count_busy(n);
    chk("sweep0_len", n, 16);

    // Test 1: fill every word with FFFF, reset, then expect a 16-cycle sweep back to zero.
    fill_all(16'hFFFF);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    count_busy(n);
    chk("t1_busy_len", n, 16);
    read_all();

    // Test 2: a byte-lane write on port 0.
    addr0 = 4'd3; data0 = 16'hABCD; we0 = 2'b11; tick();
    data0 = 16'h1234; we0 = 2'b01; tick();
    we0 = 2'b00; tick();
    repeat (LAT - 1) tick();
    chk("t2_q0", q0, 16'hAB34);

    // Test 3: both ports write address 5 in the same cycle, and lanes merge with port 1 taking priority.
    addr0 = 4'd5; data0 = 16'h1111; we0 = 2'b11;
    addr1 = 4'd5; data1 = 16'h2222; we1 = 2'b10;
    tick();
    we0 = 2'b00; we1 = 2'b00; tick();
    repeat (LAT - 1) tick();
    chk("t3_q0", q0, 16'h2211);
    chk("t3_q1", q1, 16'h2211);

    // Test 4: clear on request, and a restart at cnt=7 gives 16 more busy cycles.
    fill_all(16'hFFFF);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t4_busy_rise", busy, 1'b1);
    n = 0;
    while (ptr_m != 4'd7 && n < 50) begin n++; tick(); end
    clr = 1'b1; tick(); clr = 1'b0;
    count_busy(n);
    chk("t4_busy_len", n, 16);
    read_all();
    addr0 = 4'd0; tick(); repeat (LAT - 1) tick();
    chk("t4_word0", q0, 16'h0000);

    // Test 5: a cross-port read of a word that port 1 writes in the same cycle.
    addr1 = 4'd9; data1 = 16'h5A5A; we1 = 2'b11; addr0 = 4'd9; tick();
    we1 = 2'b00; addr1 = 4'd0;
    repeat (LAT - 1) tick();
`ifdef JTFRAME_DUAL_RAM_FWD_EN
    exp5 = 16'h5A5A;
`else
    exp5 = 16'h0000;
`endif
    chk("t5_q0", q0, exp5);
    tick(); repeat (LAT - 1) tick();
    chk("t5_after", q0, 16'h5A5A);

    // Test 6: a reset pulse mid-sweep restarts the sweep from address 0.
    fill_all(16'hFFFF);
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_q0", q0, 16'h0000);
    chk("t6_q1", q1, 16'h0000);
    chk("t6_busy", busy, 1'b1);
    count_busy(n);
    chk("t6_busy_len", n, 16);
    read_all();

    // This is the randomized phase with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      if ($urandom_range(0, 3) == 0) addr1 = addr0;
      data0 = DW'($urandom); data1 = DW'($urandom);
      we0 = BW'($urandom); we1 = BW'($urandom);
      clr = ($urandom_range(0, 59) == 0);
      tick();
    end
    clr = 1'b0; we0 = 2'b00; we1 = 2'b00;
    repeat (40) tick();
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
